// File: rtl/regfile_access_ctrl_if.sv
// Purpose: bundles the decode request, writeback, register-file and execute operand ports.
// Latency: none, wiring only.
// Backpressure: in_ready and op_ready carry the valid/ready handshakes; writeback has no ready.
//
// Signal groups
//   decode  : in_valid, in_ready, in_rs1, in_rs2, in_rd
//   wb      : wb_valid, wb_addr, wb_data
//   file    : rf_en, rf_r1, rf_r2, rf_write, rf_data (to file); rf_out1, rf_out2 (from file)
//   execute : op_valid, op_ready, op_a, op_b, op_rd
// Modports
//   slave   : the access controller
//   master  : the surrounding decode / execute / register-file environment
interface regfile_access_ctrl_if #(
    parameter int WORD_SIZE     = 64,
    parameter int REG_ADDR_SIZE = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [REG_ADDR_SIZE-1:0] in_rs1;
    logic [REG_ADDR_SIZE-1:0] in_rs2;
    logic [REG_ADDR_SIZE-1:0] in_rd;

    logic                     wb_valid;
    logic [REG_ADDR_SIZE-1:0] wb_addr;
    logic [WORD_SIZE-1:0]     wb_data;

    logic                     rf_en;
    logic [REG_ADDR_SIZE-1:0] rf_r1;
    logic [REG_ADDR_SIZE-1:0] rf_r2;
    logic [REG_ADDR_SIZE-1:0] rf_write;
    logic [WORD_SIZE-1:0]     rf_data;
    logic [WORD_SIZE-1:0]     rf_out1;
    logic [WORD_SIZE-1:0]     rf_out2;

    logic                     op_valid;
    logic                     op_ready;
    logic [WORD_SIZE-1:0]     op_a;
    logic [WORD_SIZE-1:0]     op_b;
    logic [REG_ADDR_SIZE-1:0] op_rd;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd,
        output in_ready,
        input  wb_valid, wb_addr, wb_data,
        output rf_en, rf_r1, rf_r2, rf_write, rf_data,
        input  rf_out1, rf_out2,
        output op_valid, op_a, op_b, op_rd,
        input  op_ready
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd,
        input  in_ready,
        output wb_valid, wb_addr, wb_data,
        input  rf_en, rf_r1, rf_r2, rf_write, rf_data,
        output rf_out1, rf_out2,
        input  op_valid, op_a, op_b, op_rd,
        output op_ready
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Purpose: issues dual operand reads to a registered-read register file and forwards writebacks.
// Latency: issue in cycle N -> op_valid in N+2 when execute is not stalling; one request per cycle.
// Backpressure: one request can park in a holding slot; in_ready drops (comb from op_ready) when full.
//
// Ports
//   clk, rst_n : clock (posedge) and asynchronous active-low reset
//   bus        : regfile_access_ctrl_if.slave, carrying
//                decode  in_valid/in_ready/in_rs1/in_rs2/in_rd
//                wb      wb_valid/wb_addr/wb_data (always accepted)
//                file    rf_en/rf_r1/rf_r2/rf_write/rf_data out, rf_out1/rf_out2 in
//                execute op_valid/op_ready/op_a/op_b/op_rd
//
// Build option
//   RAC_BYPASS_EN : when defined, a writeback landing in the same cycle as an issue that reads
//                   the same register is forwarded straight into the operand. When undefined
//                   there are no bypass muxes; the request is instead held off (in_ready=0)
//                   for that cycle and reads the written value from the file one cycle later.
module regfile_access_ctrl #(
    parameter int WORD_SIZE     = 64,
    parameter int REG_ADDR_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_access_ctrl_if.slave  bus
);

    typedef logic [WORD_SIZE-1:0]     word_t;
    typedef logic [REG_ADDR_SIZE-1:0] addr_t;

    // One complete operand bundle as presented to execute.
    typedef struct packed {
        addr_t rd;
        word_t a;
        word_t b;
    } opnd_t;

    // Request waiting for the file's read data. fix_x marks an operand whose value is already
    // known at issue (register 0, or a same-cycle writeback) and must not be taken from rf_out.
    typedef struct packed {
        addr_t rd;
        logic  fix_a;
        logic  fix_b;
        word_t val_a;
        word_t val_b;
    } inflight_t;

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_INFLIGHT,
        SLOT_HELD
    } slot_t;

    localparam addr_t ADDR_ZERO = '0;
    localparam word_t WORD_ZERO = '0;

    slot_t     state_q;
    slot_t     state_d;
    inflight_t inf_q;
    inflight_t inf_d;
    opnd_t     held_q;
    opnd_t     out_q;
    logic      out_vld_q;

    opnd_t     inf_opnd;
    opnd_t     load_opnd;
    logic      load_out;
    logic      latch_held;

    logic      wb_hit;
    logic      hazard_stall;
    logic      out_free;
    logic      issue;

    // ------------------------------------------------------------------
    // Handshake and file-side drive
    // ------------------------------------------------------------------
    assign wb_hit = bus.wb_valid && (bus.wb_addr != ADDR_ZERO);

`ifdef RAC_BYPASS_EN
    assign hazard_stall = 1'b0;
`else
    // Without forwarding, a read of a register being written this cycle would see the stale
    // value, so the request waits one cycle and then reads the updated file.
    assign hazard_stall = wb_hit &&
                          ((bus.wb_addr == bus.in_rs1) || (bus.wb_addr == bus.in_rs2));
`endif

    // Output register can take new data this cycle if it is empty or being drained.
    assign out_free     = !out_vld_q || bus.op_ready;
    assign bus.in_ready = rst_n && ((state_q == SLOT_EMPTY) || out_free) && !hazard_stall;
    assign issue        = bus.in_valid && bus.in_ready;

    // rst_n is folded in so that nothing reaches the file while reset is asserted.
    assign bus.rf_en    = rst_n && (issue || bus.wb_valid);
    assign bus.rf_write = (rst_n && bus.wb_valid) ? bus.wb_addr : ADDR_ZERO;
    assign bus.rf_data  = (rst_n && bus.wb_valid) ? bus.wb_data : WORD_ZERO;
    assign bus.rf_r1    = issue ? bus.in_rs1 : ADDR_ZERO;
    assign bus.rf_r2    = issue ? bus.in_rs2 : ADDR_ZERO;

    // ------------------------------------------------------------------
    // Issue-cycle capture
    // ------------------------------------------------------------------
    always_comb begin
        inf_d = inf_q;
        if (issue) begin
            inf_d.rd    = bus.in_rd;
            inf_d.fix_a = (bus.in_rs1 == ADDR_ZERO);
            inf_d.fix_b = (bus.in_rs2 == ADDR_ZERO);
            inf_d.val_a = WORD_ZERO;
            inf_d.val_b = WORD_ZERO;
`ifdef RAC_BYPASS_EN
            // The file returns the pre-write value for a same-cycle write/read, so the
            // writeback data is the value the operand must snapshot.
            if (wb_hit && (bus.wb_addr == bus.in_rs1)) begin
                inf_d.fix_a = 1'b1;
                inf_d.val_a = bus.wb_data;
            end
            if (wb_hit && (bus.wb_addr == bus.in_rs2)) begin
                inf_d.fix_b = 1'b1;
                inf_d.val_b = bus.wb_data;
            end
`endif
        end
    end

    // Operands of the in-flight request, valid only in the cycle after issue when rf_out is live.
    always_comb begin
        inf_opnd.rd = inf_q.rd;
        inf_opnd.a  = inf_q.fix_a ? inf_q.val_a : bus.rf_out1;
        inf_opnd.b  = inf_q.fix_b ? inf_q.val_b : bus.rf_out2;
    end

    // ------------------------------------------------------------------
    // Slot FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        load_out   = 1'b0;
        latch_held = 1'b0;
        load_opnd  = inf_opnd;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (issue) begin
                    state_d = SLOT_INFLIGHT;
                end
            end
            SLOT_INFLIGHT: begin
                if (out_free) begin
                    load_out = 1'b1;
                    state_d  = issue ? SLOT_INFLIGHT : SLOT_EMPTY;
                end else begin
                    // rf_out is only valid this cycle; park it before it is lost.
                    latch_held = 1'b1;
                    state_d    = SLOT_HELD;
                end
            end
            SLOT_HELD: begin
                if (out_free) begin
                    load_out  = 1'b1;
                    load_opnd = held_q;
                    state_d   = issue ? SLOT_INFLIGHT : SLOT_EMPTY;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SLOT_EMPTY;
            inf_q     <= '0;
            held_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inf_q   <= inf_d;
            if (latch_held) begin
                held_q <= inf_opnd;
            end
            if (load_out) begin
                out_q     <= load_opnd;
                out_vld_q <= 1'b1;
            end else if (bus.op_ready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.op_valid = out_vld_q;
    assign bus.op_a     = out_q.a;
    assign bus.op_b     = out_q.b;
    assign bus.op_rd    = out_q.rd;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Purpose: self-checking bench for regfile_access_ctrl with a register-file model and scoreboard.
// Latency: n/a.
// Backpressure: drives random and directed op_ready stalls.
module tb_regfile_access_ctrl;
    localparam int W  = 64;
    localparam int RA = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    regfile_access_ctrl_if #(.WORD_SIZE(W), .REG_ADDR_SIZE(RA)) ifc ();

    regfile_access_ctrl #(.WORD_SIZE(W), .REG_ADDR_SIZE(RA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Register file: registered read returning pre-write contents, register 0 reads zero.
    logic [W-1:0] rf_mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (ifc.rf_en) begin
            ifc.rf_out1 <= (ifc.rf_r1 == 0) ? '0 : rf_mem[ifc.rf_r1];
            ifc.rf_out2 <= (ifc.rf_r2 == 0) ? '0 : rf_mem[ifc.rf_r2];
            if (ifc.rf_write != 0) rf_mem[ifc.rf_write] <= ifc.rf_data;
        end
    end

    // Reference: architectural register values and the ordered list of expected operands.
    typedef struct packed {
        logic [RA-1:0] rd;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
    } exp_t;
    exp_t         expq [$];
    logic [W-1:0] arch [16] = '{default: '0};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.in_valid = 1'b0;
        ifc.in_rs1   = '0;
        ifc.in_rs2   = '0;
        ifc.in_rd    = '0;
        ifc.wb_valid = 1'b0;
        ifc.wb_addr  = '0;
        ifc.wb_data  = '0;
    endtask

    task automatic issue_req(input int rs1, input int rs2, input int rd);
        ifc.in_valid = 1'b1;
        ifc.in_rs1   = RA'(rs1);
        ifc.in_rs2   = RA'(rs2);
        ifc.in_rd    = RA'(rd);
    endtask

    task automatic wb(input int addr, input logic [W-1:0] data);
        ifc.wb_valid = 1'b1;
        ifc.wb_addr  = RA'(addr);
        ifc.wb_data  = data;
    endtask

    // Mid-cycle scoreboard: file-side drive rules and in-order operand delivery.
    task automatic monitor();
        logic iss;
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq.delete();
            end else begin
                iss = ifc.in_valid && ifc.in_ready;
                checks++;
                if (ifc.rf_en !== (iss || ifc.wb_valid)) begin
                    errors++;
                    $display("FAIL mon_rf_en: got %b want %b", ifc.rf_en, iss || ifc.wb_valid);
                end
                checks++;
                if (ifc.rf_write !== (ifc.wb_valid ? ifc.wb_addr : RA'(0))) begin
                    errors++;
                    $display("FAIL mon_rf_write: got %0d", ifc.rf_write);
                end
                checks++;
                if (ifc.rf_r1 !== (iss ? ifc.in_rs1 : RA'(0)) || ifc.rf_r2 !== (iss ? ifc.in_rs2 : RA'(0))) begin
                    errors++;
                    $display("FAIL mon_rf_rd_addr: got %0d/%0d", ifc.rf_r1, ifc.rf_r2);
                end
                if (ifc.op_valid && ifc.op_ready) begin
                    checks++;
                    got = '{rd: ifc.op_rd, a: ifc.op_a, b: ifc.op_b};
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL mon_unexpected_op: got a=%h b=%h rd=%0d", got.a, got.b, got.rd);
                    end else begin
                        e = expq.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL mon_operands: got a=%h b=%h rd=%0d want a=%h b=%h rd=%0d",
                                     got.a, got.b, got.rd, e.a, e.b, e.rd);
                        end
                    end
                end
                if (ifc.wb_valid && ifc.wb_addr != 0) arch[ifc.wb_addr] = ifc.wb_data;
                if (iss) begin
                    e.rd = ifc.in_rd;
                    e.a  = (ifc.in_rs1 == 0) ? '0 : arch[ifc.in_rs1];
                    e.b  = (ifc.in_rs2 == 0) ? '0 : arch[ifc.in_rs2];
                    expq.push_back(e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        issue_req(3, 4, 5);
        wb(5, 64'h1234);
        ifc.op_ready = 1'b1;
        repeat (2) cyc();
        checks++;
        if (ifc.op_valid !== 1'b0 || ifc.op_a !== '0 || ifc.op_b !== '0 || ifc.op_rd !== '0) begin
            errors++;
            $display("FAIL reset_op: got v=%b a=%h b=%h rd=%0d want 0", ifc.op_valid, ifc.op_a, ifc.op_b, ifc.op_rd);
        end
        checks++;
        if (ifc.in_ready !== 1'b0 || ifc.rf_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_en: got in_ready=%b rf_en=%b want 0", ifc.in_ready, ifc.rf_en);
        end
        checks++;
        if (ifc.rf_write !== '0 || ifc.rf_data !== '0 || ifc.rf_r1 !== '0 || ifc.rf_r2 !== '0) begin
            errors++;
            $display("FAIL reset_rf_bus: got w=%0d d=%h r1=%0d r2=%0d want 0", ifc.rf_write, ifc.rf_data, ifc.rf_r1, ifc.rf_r2);
        end
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        wb(3, 64'hA5);
        ifc.op_ready = 1'b1;
        cyc();
        idle_inputs();
        issue_req(3, 0, 7);
        #1;
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready: got %b want 1", ifc.in_ready);
        end
        cyc();
        idle_inputs();
        checks++;
        if (ifc.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %b want 0 at N+1", ifc.op_valid);
        end
        cyc();
        checks++;
        if (ifc.op_valid !== 1'b1 || ifc.op_a !== 64'hA5 || ifc.op_b !== '0 || ifc.op_rd !== 4'd7) begin
            errors++;
            $display("FAIL basic_operands: got v=%b a=%h b=%h rd=%0d want 1 a5 0 7", ifc.op_valid, ifc.op_a, ifc.op_b, ifc.op_rd);
        end
        cyc();
        checks++;
        if (ifc.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_pulse: got %b want 0", ifc.op_valid);
        end
    endtask

    task automatic test_hazard();
        ifc.op_ready = 1'b1;
        wb(5, 64'h11);
        issue_req(5, 0, 2);
        #1;
`ifdef RAC_BYPASS_EN
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hazard_ready: got %b want 1", ifc.in_ready);
        end
        cyc();
        idle_inputs();
        cyc();
`else
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hazard_stall: got in_ready=%b want 0", ifc.in_ready);
        end
        cyc();
        ifc.wb_valid = 1'b0;
        #1;
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hazard_retry_ready: got %b want 1", ifc.in_ready);
        end
        cyc();
        idle_inputs();
        checks++;
        if (ifc.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL hazard_early_valid: got %b want 0 at N+2", ifc.op_valid);
        end
        cyc();
`endif
        checks++;
        if (ifc.op_valid !== 1'b1 || ifc.op_a !== 64'h11 || ifc.op_rd !== 4'd2) begin
            errors++;
            $display("FAIL hazard_operand: got v=%b a=%h rd=%0d want 1 11 2", ifc.op_valid, ifc.op_a, ifc.op_rd);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got [$];
        logic         sent;
        ifc.op_ready = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            idle_inputs();
            wb(r, W'(r));
            cyc();
        end
        idle_inputs();
        ifc.op_ready = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            issue_req(r, 0, r);
            #1;
            checks++;
            if (ifc.in_ready !== (r < 3)) begin
                errors++;
                $display("FAIL bp_in_ready_%0d: got %b want %b", r, ifc.in_ready, r < 3);
            end
            if (r < 3) cyc();
        end
        cyc();
        checks++;
        if (ifc.in_ready !== 1'b0 || ifc.op_valid !== 1'b1 || ifc.op_a !== 64'd1) begin
            errors++;
            $display("FAIL bp_hold: got in_ready=%b v=%b a=%h want 0 1 1", ifc.in_ready, ifc.op_valid, ifc.op_a);
        end
        cyc();
        ifc.op_ready = 1'b1;
        sent = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (ifc.in_valid && ifc.in_ready) sent = 1'b1;
            if (ifc.op_valid && ifc.op_ready) got.push_back(ifc.op_a);
            cyc();
            if (sent) ifc.in_valid = 1'b0;
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d operands want 3", got.size());
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= got.size() || got[k] !== W'(k + 1)) begin
                errors++;
                $display("FAIL bp_order_%0d: got %h want %0d", k, (k < got.size()) ? got[k] : '0, k + 1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_snapshot();
        ifc.op_ready = 1'b1;
        wb(4, 64'h22);
        cyc();
        idle_inputs();
        ifc.op_ready = 1'b0;
        issue_req(1, 0, 8);
        cyc();
        issue_req(4, 0, 9);
        cyc();
        idle_inputs();
        wb(4, 64'h99);
        cyc();
        wb(4, 64'h77);
        cyc();
        idle_inputs();
        ifc.op_ready = 1'b1;
        #1;
        checks++;
        if (ifc.op_valid !== 1'b1 || ifc.op_a !== 64'd1 || ifc.op_rd !== 4'd8) begin
            errors++;
            $display("FAIL snap_first: got v=%b a=%h rd=%0d want 1 1 8", ifc.op_valid, ifc.op_a, ifc.op_rd);
        end
        cyc();
        checks++;
        if (ifc.op_valid !== 1'b1 || ifc.op_a !== 64'h22 || ifc.op_rd !== 4'd9) begin
            errors++;
            $display("FAIL snap_held: got v=%b a=%h rd=%0d want 1 22 9", ifc.op_valid, ifc.op_a, ifc.op_rd);
        end
        cyc();
    endtask

    task automatic test_zero();
        ifc.op_ready = 1'b1;
        wb(0, 64'hFF);
        #1;
        checks++;
        if (ifc.rf_write !== '0 || ifc.rf_en !== 1'b1) begin
            errors++;
            $display("FAIL zero_wb: got rf_write=%0d rf_en=%b want 0 1", ifc.rf_write, ifc.rf_en);
        end
        cyc();
        issue_req(0, 0, 1);
        #1;
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: got %b want 1", ifc.in_ready);
        end
        cyc();
        idle_inputs();
        cyc();
        checks++;
        if (ifc.op_valid !== 1'b1 || ifc.op_a !== '0 || ifc.op_b !== '0) begin
            errors++;
            $display("FAIL zero_operands: got v=%b a=%h b=%h want 1 0 0", ifc.op_valid, ifc.op_a, ifc.op_b);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        ifc.op_ready = 1'b0;
        issue_req(3, 4, 5);
        cyc();
        issue_req(2, 0, 6);
        cyc();
        idle_inputs();
        #1;
        checks++;
        if (ifc.op_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got op_valid=%b want 1", ifc.op_valid);
        end
        rst_n = 1'b0;
        issue_req(1, 1, 1);
        wb(6, 64'h33);
        #1;
        checks++;
        if (ifc.op_valid !== 1'b0 || ifc.in_ready !== 1'b0 || ifc.rf_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got v=%b in_ready=%b rf_en=%b want 0 0 0", ifc.op_valid, ifc.in_ready, ifc.rf_en);
        end
        cyc();
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        cyc();
        ifc.op_ready = 1'b1;
        issue_req(3, 6, 4);
        cyc();
        idle_inputs();
        cyc();
        checks++;
        if (ifc.op_valid !== 1'b1 || ifc.op_a !== 64'd3 || ifc.op_b !== '0 || ifc.op_rd !== 4'd4) begin
            errors++;
            $display("FAIL rstmid_after: got v=%b a=%h b=%h rd=%0d want 1 3 0 4", ifc.op_valid, ifc.op_a, ifc.op_b, ifc.op_rd);
        end
        cyc();
    endtask

    task automatic test_random();
        int left;
        for (int i = 0; i < 600; i++) begin
            ifc.in_valid = ($urandom_range(3) != 0);
            ifc.in_rs1   = RA'($urandom_range(15));
            ifc.in_rs2   = RA'($urandom_range(15));
            ifc.in_rd    = RA'($urandom_range(15));
            ifc.wb_valid = ($urandom_range(1) != 0);
            ifc.wb_addr  = RA'($urandom_range(15));
            ifc.wb_data  = {$urandom, $urandom};
            ifc.op_ready = ($urandom_range(2) != 0);
            cyc();
        end
        idle_inputs();
        ifc.op_ready = 1'b1;
        left = 20;
        while (expq.size() != 0 && left > 0) begin
            cyc();
            left--;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL random_drain: %0d operands never delivered within bound", expq.size());
        end
    endtask

    initial begin
        idle_inputs();
        ifc.op_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_hazard();
        test_backpressure();
        test_snapshot();
        test_zero();
        test_reset_mid();
        test_random();
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
